// File: rtl/hash_validator_pipe_if.sv
// Beat bus between the hash cores and the validator.
//   master: drives valid_i/newblock_i/difficulty/hash, receives results.
//   slave : the validator; receives the beat, drives valid_o/newblock_o/
//           success/any_success/hit_count.
interface hash_validator_pipe_if #(
  parameter int LANES = 1
);
  logic                   valid_i;
  logic                   newblock_i;
  logic [31:0]            difficulty;
  logic [LANES*256-1:0]   hash;
  logic                   valid_o;
  logic                   newblock_o;
  logic [LANES-1:0]       success;
  logic                   any_success;
  logic [31:0]            hit_count;

  modport master (
    output valid_i, newblock_i, difficulty, hash,
    input  valid_o, newblock_o, success, any_success, hit_count
  );
  modport slave (
    input  valid_i, newblock_i, difficulty, hash,
    output valid_o, newblock_o, success, any_success, hit_count
  );
endinterface

// File: rtl/hash_validator_pipe.sv
// Multi-lane pipelined hash <= target validator.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : hash_validator_pipe_if.slave (beat in, per-lane success / hit count out)
// Latency valid_i -> valid_o is 1 + 256/CHUNK_W cycles; hit_count one cycle later.

// Per-lane compare pipeline: byte-reverse the digest into its numeric value,
// then compare one CHUNK_W slice per stage, MSB slice first.
module hvp_lane #(
  parameter int CHUNK_W = 64,
  parameter int STAGES  = 4
) (
  input  logic                     clk,
  input  logic [255:0]             hash_raw,
  input  logic [STAGES-1:0][255:0] tgt,
  output logic                     le
);
  logic [255:0]                  h_num;
  logic [STAGES-1:0][255:0]      h_pipe;
  logic [STAGES:1]               dec_q, le_q, dprev, lprev;
  logic [STAGES:1][CHUNK_W-1:0]  hs, ts;

  // First digest byte is the numeric LSB.
  always_comb begin
    h_num = '0;
    for (int i = 0; i < 32; i++) h_num[8*i +: 8] = hash_raw[255-8*i -: 8];
  end

  always_comb begin
    dprev = '0;
    lprev = '0;
    hs    = '0;
    ts    = '0;
    for (int s = 1; s <= STAGES; s++) begin
      hs[s] = h_pipe[s-1][256-CHUNK_W*(s-1)-1 -: CHUNK_W];
      ts[s] = tgt[s-1][256-CHUNK_W*(s-1)-1 -: CHUNK_W];
    end
    for (int s = 2; s <= STAGES; s++) begin
      dprev[s] = dec_q[s-1];
      lprev[s] = le_q[s-1];
    end
  end

  // Once a higher slice differs, the verdict is frozen and carried along.
  always_ff @(posedge clk) begin
    h_pipe[0] <= h_num;
    for (int s = 1; s < STAGES; s++) h_pipe[s] <= h_pipe[s-1];
    for (int s = 1; s <= STAGES; s++) begin
      dec_q[s] <= dprev[s] | (hs[s] != ts[s]);
      le_q[s]  <= dprev[s] ? lprev[s] : (hs[s] < ts[s]);
    end
  end

  // Never decided means every slice matched: hash == target passes.
  assign le = dec_q[STAGES] ? le_q[STAGES] : 1'b1;
endmodule

module hash_validator_pipe #(
  parameter int LANES   = 1,
  parameter int CHUNK_W = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  hash_validator_pipe_if.slave  bus
);
  localparam int STAGES = 256 / CHUNK_W;
  localparam int POP_W  = $clog2(LANES + 1);

  logic [7:0]               exp_b;
  logic [23:0]              mant;
  logic [255:0]             tgt_new, tgt_eff, tgt_q;
  logic                     tgt_valid, nb_beat;
  logic [STAGES-1:0][255:0] tgt_pipe;
  logic [STAGES:0]          vld_pipe, nb_pipe, tv_pipe;
  logic [LANES-1:0]         le_fin, succ;
  logic [POP_W-1:0]         pop;
  logic [32:0]              hit_sum;
  logic [31:0]              hit_q;

  assign exp_b = bus.difficulty[31:24];
  assign mant  = bus.difficulty[23:0];

  // Compact nBits expansion; the mantissa is unsigned. Shifts of 256 or
  // more (exp >= 35) fall off the top and leave target 0.
  always_comb begin
    tgt_new = '0;
    if (exp_b >= 8'd3) tgt_new = {232'd0, mant} << {exp_b - 8'd3, 3'b000};
    else               tgt_new = {232'd0, mant} >> {8'd3 - exp_b, 3'b000};
  end

  // A new-block beat is compared against its own freshly expanded target.
  assign nb_beat = bus.valid_i & bus.newblock_i;
  assign tgt_eff = nb_beat ? tgt_new : tgt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tgt_q     <= '0;
      tgt_valid <= 1'b0;
      vld_pipe  <= '0;
      nb_pipe   <= '0;
      tv_pipe   <= '0;
    end else begin
      if (nb_beat) begin
        tgt_q     <= tgt_new;
        tgt_valid <= 1'b1;
      end
      vld_pipe <= {vld_pipe[STAGES-1:0], bus.valid_i};
      nb_pipe  <= {nb_pipe[STAGES-1:0], nb_beat};
      tv_pipe  <= {tv_pipe[STAGES-1:0], tgt_valid | nb_beat};
    end
  end

  // Target travels with its beat so each stage sees the matching slice.
  always_ff @(posedge clk) begin
    tgt_pipe[0] <= tgt_eff;
    for (int s = 1; s < STAGES; s++) tgt_pipe[s] <= tgt_pipe[s-1];
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    hvp_lane #(.CHUNK_W(CHUNK_W), .STAGES(STAGES)) u_lane (
      .clk      (clk),
      .hash_raw (bus.hash[256*k +: 256]),
      .tgt      (tgt_pipe),
      .le       (le_fin[k])
    );
  end

  assign succ            = le_fin & {LANES{vld_pipe[STAGES] & tv_pipe[STAGES]}};
  assign bus.valid_o     = vld_pipe[STAGES];
  assign bus.newblock_o  = vld_pipe[STAGES] & nb_pipe[STAGES];
  assign bus.success     = succ;
  assign bus.any_success = |succ;
  assign bus.hit_count   = hit_q;

  always_comb begin
    pop = '0;
    for (int k = 0; k < LANES; k++) pop = pop + POP_W'(succ[k]);
  end

  assign hit_sum = {1'b0, hit_q} + 33'(pop);

  always_ff @(posedge clk) begin
    if (rst)                  hit_q <= '0;
    else if (bus.newblock_o)  hit_q <= 32'(pop);
    else if (bus.valid_o)     hit_q <= hit_sum[32] ? 32'hFFFF_FFFF : hit_sum[31:0];
  end
endmodule

// File: tb/tb_hash_validator_pipe.sv
`timescale 1ns/1ps
module tb_hash_validator_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hash_validator_pipe_if #(.LANES(1)) b1 ();
  hash_validator_pipe_if #(.LANES(4)) b4 ();

  hash_validator_pipe #(.LANES(1), .CHUNK_W(64)) u1 (.clk(clk), .rst(rst), .bus(b1));
  hash_validator_pipe #(.LANES(4), .CHUNK_W(32)) u4 (.clk(clk), .rst(rst), .bus(b4));

  typedef struct { int due; logic nb; logic [3:0] succ; } exp_t;
  exp_t q1[$], q4[$];
  exp_t e1, e4;
  int   total = 0, bad = 0, cyc = 0;
  logic [31:0] hm1 = '0, hm4 = '0;
  bit   chk1 = 0, chk4 = 0, armed = 0;
  logic [255:0] t_eq, v_sw;
  logic [3:0][255:0] lanes;

  function automatic logic [255:0] to_raw(input logic [255:0] n);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[255-8*i -: 8] = n[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] h, input int p);
    logic [32:0] s;
    s = {1'b0, h} + 33'(p);
    return (s > 33'h0_FFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (armed) begin
      if (chk1) begin
        total++;
        if (b1.hit_count !== hm1) begin bad++; $error("FAIL hit1: got %0h want %0h", b1.hit_count, hm1); end
      end
      chk1 = 0;
      if (b1.valid_o) begin
        if (q1.size() == 0) begin
          total++;
          if (b1.valid_o !== 1'b0) begin bad++; $error("FAIL spurious1: got %0h want %0h", b1.valid_o, 1'b0); end
        end else begin
          e1 = q1.pop_front();
          total++;
          if (cyc !== e1.due) begin bad++; $error("FAIL lat1: got %0h want %0h", cyc, e1.due); end
          total++;
          if (b1.success !== e1.succ[0]) begin bad++; $error("FAIL succ1: got %0h want %0h", b1.success, e1.succ[0]); end
          total++;
          if (b1.any_success !== e1.succ[0]) begin bad++; $error("FAIL any1: got %0h want %0h", b1.any_success, e1.succ[0]); end
          total++;
          if (b1.newblock_o !== e1.nb) begin bad++; $error("FAIL nb1: got %0h want %0h", b1.newblock_o, e1.nb); end
          hm1 = e1.nb ? 32'($countones(e1.succ)) : sat_add(hm1, $countones(e1.succ));
          chk1 = 1;
        end
      end else begin
        total++;
        if ({b1.newblock_o, b1.any_success, b1.success} !== 3'b000) begin
          bad++; $error("FAIL idle1: got %0h want %0h", {b1.newblock_o, b1.any_success, b1.success}, 3'b000);
        end
        if (q1.size() > 0 && q1[0].due <= cyc) begin
          total++;
          if (b1.valid_o !== 1'b1) begin bad++; $error("FAIL missing1: got %0h want %0h", b1.valid_o, 1'b1); end
          void'(q1.pop_front());
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (armed) begin
      if (chk4) begin
        total++;
        if (b4.hit_count !== hm4) begin bad++; $error("FAIL hit4: got %0h want %0h", b4.hit_count, hm4); end
      end
      chk4 = 0;
      if (b4.valid_o) begin
        if (q4.size() == 0) begin
          total++;
          if (b4.valid_o !== 1'b0) begin bad++; $error("FAIL spurious4: got %0h want %0h", b4.valid_o, 1'b0); end
        end else begin
          e4 = q4.pop_front();
          total++;
          if (cyc !== e4.due) begin bad++; $error("FAIL lat4: got %0h want %0h", cyc, e4.due); end
          total++;
          if (b4.success !== e4.succ) begin bad++; $error("FAIL succ4: got %0h want %0h", b4.success, e4.succ); end
          total++;
          if (b4.any_success !== (|e4.succ)) begin bad++; $error("FAIL any4: got %0h want %0h", b4.any_success, |e4.succ); end
          total++;
          if (b4.newblock_o !== e4.nb) begin bad++; $error("FAIL nb4: got %0h want %0h", b4.newblock_o, e4.nb); end
          hm4 = e4.nb ? 32'($countones(e4.succ)) : sat_add(hm4, $countones(e4.succ));
          chk4 = 1;
        end
      end else begin
        total++;
        if ({b4.newblock_o, b4.any_success, b4.success} !== 6'b0) begin
          bad++; $error("FAIL idle4: got %0h want %0h", {b4.newblock_o, b4.any_success, b4.success}, 6'b0);
        end
        if (q4.size() > 0 && q4[0].due <= cyc) begin
          total++;
          if (b4.valid_o !== 1'b1) begin bad++; $error("FAIL missing4: got %0h want %0h", b4.valid_o, 1'b1); end
          void'(q4.pop_front());
        end
      end
    end
  end

  task automatic beat1(input logic nb, input logic [31:0] d, input logic [255:0] num,
                       input logic s);
    b1.valid_i = 1'b1; b1.newblock_i = nb; b1.difficulty = d; b1.hash = to_raw(num);
    q1.push_back('{cyc + 5, nb, {3'b000, s}});
    @(negedge clk);
    b1.valid_i = 1'b0; b1.newblock_i = 1'b0;
  endtask

  task automatic beat4(input logic nb, input logic [31:0] d, input logic [3:0][255:0] nums,
                       input logic [3:0] s);
    b4.valid_i = 1'b1; b4.newblock_i = nb; b4.difficulty = d;
    for (int k = 0; k < 4; k++) b4.hash[256*k +: 256] = to_raw(nums[k]);
    q4.push_back('{cyc + 9, nb, s});
    @(negedge clk);
    b4.valid_i = 1'b0; b4.newblock_i = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    q1.delete(); q4.delete();
    hm1 = '0; hm4 = '0; chk1 = 0; chk4 = 0;
    b1.valid_i = 1'b1; b1.newblock_i = 1'b1; b1.difficulty = 32'h2000ffff; b1.hash = '0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    b1.valid_i = 1'b0; b1.newblock_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    b1.valid_i = 0; b1.newblock_i = 0; b1.difficulty = '0; b1.hash = '0;
    b4.valid_i = 0; b4.newblock_i = 0; b4.difficulty = '0; b4.hash = '0;
    t_eq = 256'hffff << 208;
    v_sw = 256'hff << 216;
    repeat (2) @(negedge clk);
    armed = 1;
    total++;
    if (b1.valid_o !== 1'b0) begin bad++; $error("FAIL rst_valid_o: got %0h want %0h", b1.valid_o, 1'b0); end
    total++;
    if (b1.success !== 1'b0) begin bad++; $error("FAIL rst_success: got %0h want %0h", b1.success, 1'b0); end
    total++;
    if (b1.newblock_o !== 1'b0) begin bad++; $error("FAIL rst_nb: got %0h want %0h", b1.newblock_o, 1'b0); end
    total++;
    if (b1.hit_count !== 32'd0) begin bad++; $error("FAIL rst_hit: got %0h want %0h", b1.hit_count, 32'd0); end
    total++;
    if (b4.hit_count !== 32'd0) begin bad++; $error("FAIL rst_hit4: got %0h want %0h", b4.hit_count, 32'd0); end
    rst = 1'b0;
    @(negedge clk);

    beat1(0, 32'h1d00ffff, '0, 0);
    beat1(0, 32'h1d00ffff, '0, 0);
    repeat (7) @(negedge clk);
    total++;
    if (b1.hit_count !== 32'd0) begin bad++; $error("FAIL notgt_hit: got %0h want %0h", b1.hit_count, 32'd0); end
    beat1(1, 32'h2000ffff, '0, 1);
    repeat (7) @(negedge clk);
    total++;
    if (b1.hit_count !== 32'd1) begin bad++; $error("FAIL first_nb_hit: got %0h want %0h", b1.hit_count, 32'd1); end

    beat1(1, 32'h1d00ffff, t_eq, 1);
    beat1(0, 32'h0, t_eq + 1, 0);
    beat1(0, 32'h0, t_eq - 1, 1);
    repeat (7) @(negedge clk);
    total++;
    if (b1.hit_count !== 32'd2) begin bad++; $error("FAIL eq_hit: got %0h want %0h", b1.hit_count, 32'd2); end

    beat1(1, 32'h02001234, 256'h12, 1);
    beat1(0, 32'h0, 256'h13, 0);
    beat1(1, 32'h23010000, 256'h1, 0);
    beat1(0, 32'h0, 256'h0, 1);
    beat1(1, 32'h04800000, 256'h80000000, 1);
    beat1(0, 32'h0, 256'h80000001, 0);
    repeat (7) @(negedge clk);
    total++;
    if (b1.hit_count !== 32'd1) begin bad++; $error("FAIL small_hit: got %0h want %0h", b1.hit_count, 32'd1); end

    beat1(1, 32'h1d00ffff, v_sw, 1);
    beat1(0, 32'h0, v_sw, 1);
    beat1(1, 32'h1c00ffff, v_sw, 0);
    repeat (7) @(negedge clk);
    total++;
    if (b1.hit_count !== 32'd0) begin bad++; $error("FAIL switch_hit: got %0h want %0h", b1.hit_count, 32'd0); end
    beat1(1, 32'h1c00ffff, v_sw, 0);
    beat1(1, 32'h1d00ffff, v_sw, 1);
    beat1(1, 32'h1c00ffff, v_sw, 0);
    repeat (7) @(negedge clk);
    total++;
    if (b1.hit_count !== 32'd0) begin bad++; $error("FAIL b2b_hit: got %0h want %0h", b1.hit_count, 32'd0); end

    beat1(1, 32'h1d00ffff, t_eq, 1);
    beat1(0, 32'h0, t_eq, 1);
    beat1(0, 32'h0, t_eq, 1);
    do_reset(1);
    @(negedge clk);
    beat1(0, 32'h0, '0, 0);
    repeat (7) @(negedge clk);
    total++;
    if (b1.hit_count !== 32'd0) begin bad++; $error("FAIL postrst_hit: got %0h want %0h", b1.hit_count, 32'd0); end

    lanes[0] = '0; lanes[1] = t_eq + 1; lanes[2] = t_eq; lanes[3] = t_eq - 1;
    beat4(1, 32'h1d00ffff, lanes, 4'b1101);
    beat4(0, 32'h0, lanes, 4'b1101);
    repeat (11) @(negedge clk);
    total++;
    if (b4.hit_count !== 32'd6) begin bad++; $error("FAIL lanes_hit: got %0h want %0h", b4.hit_count, 32'd6); end

    force u4.hit_q = 32'hFFFF_FFFE;
    #1;
    release u4.hit_q;
    hm4 = 32'hFFFF_FFFE;
    @(negedge clk);
    total++;
    if (b4.hit_count !== 32'hFFFF_FFFE) begin bad++; $error("FAIL preload_hit: got %0h want %0h", b4.hit_count, 32'hFFFF_FFFE); end
    beat4(0, 32'h0, lanes, 4'b1101);
    beat4(0, 32'h0, lanes, 4'b1101);
    repeat (11) @(negedge clk);
    total++;
    if (b4.hit_count !== 32'hFFFF_FFFF) begin bad++; $error("FAIL sat_hit: got %0h want %0h", b4.hit_count, 32'hFFFF_FFFF); end
    total++;
    if (q1.size() !== 0) begin bad++; $error("FAIL drained1: got %0h want %0h", q1.size(), 0); end
    total++;
    if (q4.size() !== 0) begin bad++; $error("FAIL drained4: got %0h want %0h", q4.size(), 0); end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hash_validator_pipe.md
# hash_validator_pipe

Pipelined, multi-lane successor to the single-lane hash validator. It compares each lane's 256-bit double-SHA hash against the target expanded from the compact `difficulty` word. The target is latched on a new-block beat, and the magnitude compare is split into `CHUNK_W`-bit slices across pipeline stages so it closes timing at full clock. The block sits directly behind the hash cores and feeds the nonce-report logic with per-lane success flags and a running hit count.

## Interface
- `LANES`, 1, number of hash lanes checked per beat.
- `CHUNK_W`, 64, compare slice width; must divide 256; `STAGES = 256/CHUNK_W`.
- `clk`  in  1  sole clock; everything is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `valid_i`  in  1  beat valid.
- `newblock_i`  in  1  beat starts a new block; only meaningful when `valid_i` = 1.
- `difficulty`  in  32  compact target (nBits); sampled only when `valid_i & newblock_i`.
- `hash`  in  `LANES*256`  lane k occupies `[256k+255:256k]`.
- `valid_o`  out  1  `valid_i` delayed by the block latency.
- `newblock_o`  out  1  `newblock_i & valid_i` delayed by the block latency.
- `success`  out  `LANES`  bit k = lane k hash ≤ target; qualified by `valid_o`.
- `any_success`  out  1  OR of `success`, qualified by `valid_o`.
- `hit_count`  out  32  successes since the last new block, saturating.

## Operation
- Hash numeric value: digest byte order is reversed.
  - Numeric byte i (i = 0 is least significant) = `hash_lane[255-8i -: 8]`.
  - So the first digest byte is the numeric LSB.
- Target expansion:
  - `exp = difficulty[31:24]`; `mant = difficulty[23:0]`, taken unsigned, with bit 23 treated as data, not sign.
  - `exp ≥ 3`: target = `mant << 8*(exp-3)`, truncated to 256 bits. Bits shifted out are lost; `exp ≥ 35` gives target 0.
  - `exp < 3`: target = `mant >> 8*(3-exp)`.
- Stage 0 (input register):
  - Registers `hash`, `valid_i` and `newblock_i & valid_i`.
  - Registers the effective target: the freshly expanded value on a new-block beat, else the held target register.
  - A new-block beat is therefore compared against its own new target. The held target updates on the same edge.
- `tgt_valid` flag:
  - Cleared by reset; set by the first valid new-block beat.
  - Beats registered while `tgt_valid` = 0 report `success` = 0 on all lanes, even for hash 0.
- Compare stages 1..`STAGES`:
  - Stage s compares slice `[256-CHUNK_W*(s-1)-1 -: CHUNK_W]` of the hash number and the target, MSB slice first.
  - Per lane it carries `decided` and `le` flags. An undecided lane becomes decided on the first unequal slice, with `le` = (hash slice < target slice).
  - A lane still undecided after the last stage is equal, so `le` = 1.
  - `success[k]` = final `le[k] & tgt_valid_at_beat & valid`.
- `hit_count`:
  - On each `valid_o` beat, add popcount(`success`), saturating at 0xFFFFFFFF.
  - On a `newblock_o` beat, load popcount(`success`) of that beat instead, discarding the old count.
- Beats with `valid_i` = 0 carry no meaning. `success`, `any_success` and `newblock_o` are 0 whenever `valid_o` = 0.
- Throughput: one beat per cycle, no backpressure, no bubbles required.

## Timing
- Latency from a `valid_i` beat to its `valid_o`/`success` is `1 + STAGES` cycles; the default is 5.
- `hit_count` reflects a beat one cycle after that beat's `valid_o` (registered).
- Reset values:
  - `valid_o`, `newblock_o`, `success`, `any_success`: 0.
  - `hit_count`: 0; target register: 0; `tgt_valid`: 0.
- Reset mid-stream:
  - All pipeline valid bits clear on the reset edge, and in-flight beats are dropped; no output asserts for them.
  - The first beat accepted after reset deasserts emerges `1 + STAGES` cycles later.
- Back-to-back new-block beats: each beat uses its own difficulty; there is no cross-contamination between adjacent beats.
- Simultaneous `rst` and `valid_i`: reset wins and the beat is dropped.

## Test plan
- Equality boundary:
  - Stimulus: `difficulty` = 0x1d00ffff with newblock; lane 0 numeric value = 0x00000000ffff0000…00 (equal to target).
  - Response: `success` = 1 at cycle 5.
  - Next beat, same value + 1: `success` = 0.
  - Next beat, value − 1: `success` = 1.
- No target loaded:
  - Stimulus: after reset, valid beats with hash = 0 and no newblock.
  - Response: `success` = 0 and `hit_count` = 0.
  - Then a newblock with `difficulty` 0x2000ffff and hash 0 gives `success` = 1.
- Small exponent:
  - Stimulus: `difficulty` = 0x02001234 (target = 0x12).
  - Response: numeric value 0x12 gives 1; 0x13 gives 0.
  - Also `difficulty` = 0x23010000 (exp 35): target 0, and only hash 0 passes.
- Target switch:
  - Stimulus: consecutive beats A (newblock, 0x1d00ffff), B (no newblock), C (newblock, 0x1c00ffff), all with numeric value 0x00000000ff000000…00.
  - Response: A = 1, B = 1, C = 0.
  - `hit_count` reads 2 after B and 0 after C.
- Multi-lane with `LANES` = 4, `CHUNK_W` = 32:
  - Stimulus: lanes pass/fail/pass/pass.
  - Response: `success` = 4'b1101 at cycle 9, `any_success` = 1, `hit_count` += 3.
  - Saturation check: preload via 0xFFFFFFFE hits; the count stays at 0xFFFFFFFF.
- Reset mid-stream:
  - Stimulus: 3 valid beats in flight, then `rst` asserted for 1 cycle.
  - Response: no `valid_o` for those beats; `hit_count` = 0.
  - A beat 2 cycles after reset emerges exactly 5 cycles later with `success` = 0 (no target loaded).
